// File: rtl/instr_mem_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
// Holds the FSM state encoding and write-enable constants.
package instr_mem_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
    S_VRD_ADDR,
    S_VRD_DATA,
    S_DONE
  } state_e;

  localparam logic [3:0] WE_ALL  = 4'hF;
  localparam logic [3:0] WE_NONE = 4'h0;

endpackage

// File: rtl/instr_mem_loader_word_assembler.sv
// Packs a little-endian byte stream into 32-bit words.
// word_o already includes the byte being offered this cycle.
module word_assembler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_i,
  input  logic        take_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        last_o
);

  logic [31:0] word_q;
  logic [1:0]  idx_q;

  always_comb begin
    word_o = word_q;
    word_o[8*idx_q +: 8] = byte_i;
  end

  assign last_o = take_i & (idx_q == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      idx_q  <= '0;
    end else if (clr_i) begin
      word_q <= '0;
      idx_q  <= '0;
    end else if (take_i) begin
      word_q <= word_o;
      idx_q  <= idx_q + 2'd1;
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Streams bytes into instruction memory through the debug port,
// then optionally reads it back and compares XOR checksums.
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int VERIFY_EN = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [CNT_W-1:0] word_count,
  input  logic [7:0]       byte_data,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic [31:0]      A2,
  output logic [31:0]      WD2,
  output logic [3:0]       WE2,
  input  logic [31:0]      RD2,
  output logic             cpu_hold,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] words_done
);

  state_e           state_q;
  logic [31:0]      base_q, a2_q, wd2_q;
  logic [31:0]      csum_w_q, csum_r_q;
  logic [CNT_W-1:0] cnt_q, wdone_q, vidx_q;
  logic [3:0]       we2_q;
  logic             rdy_q, hold_q, done_q, err_q;

  logic             idle_like, clr, take, last;
  logic [31:0]      word;
  logic [CNT_W-1:0] wdone_d, vidx_d;
  logic [31:0]      wr_addr_d, vrd_addr_d, csum_r_d;

  assign idle_like = (state_q == S_IDLE) ||
                     (state_q == S_DONE);
  assign clr  = start & idle_like;
  assign take = byte_valid & rdy_q;

  assign wdone_d    = wdone_q + CNT_W'(1);
  assign vidx_d     = vidx_q + CNT_W'(1);
  assign wr_addr_d  = base_q + (32'(wdone_q) << 2);
  assign vrd_addr_d = base_q + (32'(vidx_d) << 2);
  assign csum_r_d   = csum_r_q ^ RD2;

  word_assembler u_asm (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (clr),
    .take_i (take),
    .byte_i (byte_data),
    .word_o (word),
    .last_o (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      base_q   <= '0;
      cnt_q    <= '0;
      wdone_q  <= '0;
      vidx_q   <= '0;
      csum_w_q <= '0;
      csum_r_q <= '0;
      a2_q     <= '0;
      wd2_q    <= '0;
      we2_q    <= WE_NONE;
      rdy_q    <= 1'b0;
      hold_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            base_q   <= base_addr & ~32'h3;
            cnt_q    <= word_count;
            wdone_q  <= '0;
            vidx_q   <= '0;
            csum_w_q <= '0;
            csum_r_q <= '0;
            err_q    <= 1'b0;
            if (word_count == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_RECV;
              done_q  <= 1'b0;
              rdy_q   <= 1'b1;
              hold_q  <= 1'b1;
            end
          end
        end
        S_RECV: begin
          if (last) begin
            state_q <= S_WRITE;
            rdy_q   <= 1'b0;
            a2_q    <= wr_addr_d;
            wd2_q   <= word;
            we2_q   <= WE_ALL;
          end
        end
        S_WRITE: begin
          we2_q    <= WE_NONE;
          csum_w_q <= csum_w_q ^ wd2_q;
          wdone_q  <= wdone_d;
          if (wdone_d != cnt_q) begin
            state_q <= S_RECV;
            rdy_q   <= 1'b1;
          end else if (VERIFY_EN != 0) begin
            state_q <= S_VRD_ADDR;
            a2_q    <= base_q;
            vidx_q  <= '0;
          end else begin
            state_q <= S_DONE;
            hold_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        S_VRD_ADDR: begin
          state_q <= S_VRD_DATA;
        end
        S_VRD_DATA: begin
          // RD2 now reflects the address presented last cycle
          csum_r_q <= csum_r_d;
          if (vidx_d == cnt_q) begin
            state_q <= S_DONE;
            hold_q  <= 1'b0;
            done_q  <= 1'b1;
            err_q   <= (csum_r_d != csum_w_q);
          end else begin
            state_q <= S_VRD_ADDR;
            vidx_q  <= vidx_d;
            a2_q    <= vrd_addr_d;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign byte_ready = rdy_q;
  assign A2         = a2_q;
  assign WD2        = wd2_q;
  assign WE2        = we2_q;
  assign cpu_hold   = hold_q;
  assign done       = done_q;
  assign err        = err_q;
  assign words_done = wdone_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader with a BRAM model.
// Expected writes/completions are queued; a monitor checks them.
module tb_instr_mem_loader;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n, start;
  logic [31:0]      base_addr;
  logic [CNT_W-1:0] word_count;
  logic [7:0]       byte_data;
  logic             byte_valid, byte_ready;
  logic [31:0]      A2, WD2, RD2;
  logic [3:0]       WE2;
  logic             cpu_hold, done, err;
  logic [CNT_W-1:0] words_done;

  always #5 clk = ~clk;

  instr_mem_loader #(.VERIFY_EN(1), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .A2         (A2),
    .WD2        (WD2),
    .WE2        (WE2),
    .RD2        (RD2),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .err        (err),
    .words_done (words_done)
  );

  // synchronous BRAM model; optional corruption of the word at 0x104
  logic [31:0] mem [logic [31:0]];
  bit          corrupt = 1'b0;

  always @(posedge clk)
    if (WE2 == 4'hF) mem[A2] = WD2;

  always @(posedge clk)
    RD2 <= (mem.exists(A2) ? mem[A2] : 32'h0) ^
           ((corrupt && A2 == 32'h104) ? 32'h1 : 32'h0);

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t         wq[$];
  bit          dq[$];
  logic [7:0]  bytes_q[$];
  int          n_cmp = 0;
  int          n_mis = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_mis++;
    $display("FAIL %s: got timeout/unexpected expected event", nm);
  endtask

  // monitor
  bit  done_prev = 1'b0;
  wr_t mon_w;
  bit  mon_e;

  always @(negedge clk) begin
    if (rst_n) begin
      if (WE2 != 4'h0) begin
        if (wq.size() == 0) begin
          n_cmp++;
          n_mis++;
          $display("FAIL unexpected_write: got A2=%h WD2=%h expected none",
                   A2, WD2);
        end else begin
          mon_w = wq.pop_front();
          chk("wr_addr", A2, mon_w.a);
          chk("wr_data", WD2, mon_w.d);
          chk("wr_en", 32'(WE2), 32'hF);
        end
      end
      if (done && !done_prev) begin
        if (dq.size() == 0) fail_now("unexpected_done");
        else begin
          mon_e = dq.pop_front();
          chk("err", 32'(err), 32'(mon_e));
          chk("hold_at_done", 32'(cpu_hold), 32'h0);
        end
      end
    end
    done_prev = done;
  end

  task automatic chk_reset_vals();
    chk("rst_A2", A2, 32'h0);
    chk("rst_WD2", WD2, 32'h0);
    chk("rst_WE2", 32'(WE2), 32'h0);
    chk("rst_ready", 32'(byte_ready), 32'h0);
    chk("rst_hold", 32'(cpu_hold), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_wdone", 32'(words_done), 32'h0);
  endtask

  // stop_at < 0: full load; otherwise reset after that many bytes
  task automatic run_load(input logic [31:0] base, input int n,
                          input int vprob, input bit poke,
                          input bit cor, input int stop_at);
    logic [31:0] a;
    int lim, i, cyc;
    bit pend, rs, hit, poked;
    lim = (stop_at >= 0) ? stop_at : 4 * n;
    i = 0; cyc = 0; pend = 0; rs = 0; hit = 0; poked = 0;
    corrupt = cor;
    for (int k = 0; k < lim / 4; k++) begin
      a = (base & ~32'h3) + 32'(4 * k);
      hit |= (a == 32'h104);
      wq.push_back('{a, {bytes_q[4*k+3], bytes_q[4*k+2],
                         bytes_q[4*k+1], bytes_q[4*k]}});
    end
    if (stop_at < 0) dq.push_back(cor && hit);
    @(negedge clk);
    start = 1'b1;
    base_addr = base;
    word_count = CNT_W'(n);
    while (i < lim) begin
      @(negedge clk);
      if (pend && rs) i++;
      pend = 0;
      if (poke && !poked && i == 1) begin
        start = 1'b1;
        base_addr = $urandom;
        word_count = CNT_W'($urandom);
        poked = 1;
      end else start = 1'b0;
      if (i < lim) begin
        cyc++;
        if (cyc > 4000) break;
        if ($urandom_range(99) < vprob) begin
          byte_valid = 1'b1;
          byte_data = bytes_q[i];
          pend = 1;
          rs = byte_ready;
        end else begin
          byte_valid = 1'b0;
          byte_data = 8'($urandom);
        end
      end
    end
    byte_valid = 1'b0;
    start = 1'b0;
    if (i < lim) fail_now("byte_stream_timeout");
    if (stop_at >= 0) begin
      rst_n = 1'b0;
      #1;
      chk_reset_vals();
      chk("partial_writes_left", 32'(wq.size()), 32'h0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
    end else begin
      cyc = 0;
      while (!done && cyc < 4000) begin
        @(negedge clk);
        cyc++;
      end
      if (!done) fail_now("done_timeout");
      else begin
        chk("words_done", 32'(words_done), 32'(n));
        chk("ready_at_done", 32'(byte_ready), 32'h0);
      end
    end
  endtask

  task automatic fill_rand(input int n);
    bytes_q.delete();
    for (int k = 0; k < 4 * n; k++) bytes_q.push_back(8'($urandom));
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    start = 1'b0;
    base_addr = '0;
    word_count = '0;
    byte_data = '0;
    byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals();
    rst_n = 1'b1;

    // zero-length load: DONE right after start, no writes
    @(negedge clk);
    start = 1'b1;
    base_addr = 32'h40;
    word_count = '0;
    dq.push_back(1'b0);
    @(negedge clk);
    start = 1'b0;
    chk("zero_done", 32'(done), 32'h1);
    chk("zero_hold", 32'(cpu_hold), 32'h0);
    chk("zero_wdone", 32'(words_done), 32'h0);

    bytes_q = '{8'h13, 8'h00, 8'h00, 8'h00,
                8'h93, 8'h00, 8'h10, 8'h00};
    run_load(32'h100, 2, 100, 1'b0, 1'b0, -1);
    run_load(32'h100, 2, 100, 1'b0, 1'b1, -1);

    for (int t = 0; t < 6; t++) begin
      n = $urandom_range(1, 6);
      fill_rand(n);
      run_load($urandom, n, 50, t[0], 1'b0, -1);
    end

    fill_rand(2);
    run_load(32'hFFFF_FFFC, 2, 70, 1'b0, 1'b0, -1);

    fill_rand(3);
    run_load(32'h200, 3, 60, 1'b0, 1'b0, 5);

    fill_rand(3);
    run_load(32'h300, 3, 80, 1'b1, 1'b0, -1);

    repeat (4) @(negedge clk);
    chk("writes_pending", 32'(wq.size()), 32'h0);
    chk("done_pending", 32'(dq.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/instr_mem_loader.md
INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 SHALL have parameter VERIFY_EN, default 1, meaning 1 enables the read-back verify pass after loading.
REQ-002 SHALL have parameter CNT_W, default 16, meaning the width of the word counter.
REQ-003 SHALL have port clk  input  1  single clock; all logic is rising-edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle pulse that begins a load; ignored unless IDLE or DONE.
REQ-006 SHALL have port base_addr  input  32  byte address of the first word, sampled on start; bits [1:0] forced to 0.
REQ-007 SHALL have port word_count  input  CNT_W  number of words to load, sampled on start.
REQ-008 SHALL have port byte_data  input  8  program byte stream, little-endian within each word.
REQ-009 SHALL have port byte_valid  input  1  byte_data valid.
REQ-010 SHALL have port byte_ready  output  1  loader accepts a byte; transfer occurs when byte_valid & byte_ready.
REQ-011 SHALL have port A2  output  32  instruction-memory debug port byte address.
REQ-012 SHALL have port WD2  output  32  debug port write data.
REQ-013 SHALL have port WE2  output  4  debug port byte write enables.
REQ-014 SHALL have port RD2  input  32  debug port read data, valid one cycle after A2 is presented (synchronous BRAM).
REQ-015 SHALL have port cpu_hold  output  1  high while busy, to stall/clear the pipeline front end.
REQ-016 SHALL have port done  output  1  sticky high after completion until the next start.
REQ-017 SHALL have port err  output  1  sticky verify-mismatch flag, cleared on start.
REQ-018 SHALL have port words_done  output  CNT_W  words written so far.

Function
REQ-019 SHALL implement states IDLE, RECV, WRITE, VRD_ADDR, VRD_DATA, DONE.
REQ-020 On start in IDLE/DONE, SHALL latch base/count, clear done/err/words_done/byte index/checksum, and go to RECV; if word_count==0, SHALL go directly to DONE.
REQ-021 In RECV, byte_ready SHALL be 1; each accepted byte SHALL go into lane byte_idx (byte 0 -> WD2[7:0]); after the 4th byte, SHALL go to WRITE.
REQ-022 In WRITE (exactly one cycle), SHALL drive WE2=4'hF, A2=base+4*words_done, WD2=assembled word, XOR the word into checksum_w, increment words_done, then return to RECV or leave when words_done reaches word_count.
REQ-023 WE2 SHALL be 4'h0 in every state other than WRITE; byte_ready SHALL be 0 outside RECV.
REQ-024 After the last write, SHALL go to VRD_ADDR if VERIFY_EN=1, else to DONE.
REQ-025 VRD_ADDR SHALL drive A2 for word i; the next cycle, VRD_DATA SHALL XOR RD2 into checksum_r; this SHALL repeat for i = 0..word_count-1 (2 cycles per word).
REQ-026 On verify end, SHALL set err=1 if checksum_r != checksum_w, then go to DONE.
REQ-027 Address arithmetic SHALL be 32-bit modulo 2^32; wrap-around is permitted and not flagged.
REQ-028 A start pulse arriving while in RECV/WRITE/VRD_* SHALL be ignored.
REQ-029 byte_valid while byte_ready=0 SHALL NOT be consumed.
REQ-030 cpu_hold SHALL be 1 in all states except IDLE and DONE.

Reset
REQ-031 With rst_n low, SHALL asynchronously enter IDLE with: A2=0, WD2=0, WE2=0, byte_ready=0, cpu_hold=0, done=0, err=0, words_done=0, checksums=0.
REQ-032 When reset asserts mid-load, SHALL abort without issuing a further write; a partially written memory is acceptable.

Structure
REQ-033 The state encoding and the WE_ALL=4'hF constant SHALL live in the shared cpu package.
REQ-034 SHALL instantiate one sub-module, word_assembler (byte-to-word packing with byte index); the rest SHALL be flat.

Verification
REQ-035 Load 2 words at base 0x100, bytes 13 00 00 00 93 00 10 00 -> writes 0x00000013 at A2=0x100 and 0x00100093 at A2=0x104, done=1, err=0.
REQ-036 Memory model corrupts the word at 0x104 -> err=1, done=1.
REQ-037 word_count=0 -> DONE the cycle after start, with no WE2 activity.
REQ-038 byte_valid toggled 1/0 randomly -> same writes as the continuous stream, and no byte is lost or duplicated.
REQ-039 rst_n asserted after 5 bytes -> all outputs are reset values immediately; WE2 never pulses for the partial word.
REQ-040 base_addr=0xFFFFFFFC, 2 words -> writes at 0xFFFFFFFC then 0x00000000.
